// File: rtl/wb_pkg.sv
// Shared constants for the Wishbone arbiter: bus defaults, FSM encoding and
// wait-counter sizing.
package wb_pkg;

   localparam int WB_NUM_MASTERS = 2;
   localparam int WB_ADR_WIDTH   = 30;
   localparam int WB_DAT_WIDTH   = 32;
   localparam int WB_TIMEOUT     = 255;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // Counter must be able to hold the TIMEOUT value itself.
   function automatic int wait_cnt_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester found searching upward
// from last+1 with wrap-around.
module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_last,
   output logic [IDX_W-1:0] o_grant,
   output logic             o_valid
);

   int w_cand;

   // Walk from farthest to nearest so the closest requester after i_last wins.
   always_comb begin
      o_grant = '0;
      o_valid = 1'b0;
      w_cand  = 0;
      for (int i = N; i >= 1; i--) begin
         w_cand = (int'(i_last) + i) % N;
         if (i_req[w_cand]) begin
            o_grant = IDX_W'(w_cand);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Wishbone N:1 round-robin bus arbiter with non-preemptive ownership and an
// optional slave wait timeout that reports an error to the owner.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int NUM_MASTERS = WB_NUM_MASTERS,
   parameter int ADR_WIDTH   = WB_ADR_WIDTH,
   parameter int DAT_WIDTH   = WB_DAT_WIDTH,
   parameter int TIMEOUT     = WB_TIMEOUT
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_MASTERS-1:0]             m_cyc_i,
   input  logic [NUM_MASTERS-1:0]             m_stb_i,
   input  logic [NUM_MASTERS-1:0]             m_we_i,
   input  logic [NUM_MASTERS*ADR_WIDTH-1:0]   m_adr_i,
   input  logic [NUM_MASTERS*DAT_WIDTH-1:0]   m_dat_i,
   input  logic [NUM_MASTERS*DAT_WIDTH/8-1:0] m_sel_i,
   output logic [NUM_MASTERS-1:0]             m_ack_o,
   output logic [NUM_MASTERS-1:0]             m_err_o,
   output logic [DAT_WIDTH-1:0]               m_dat_o,
   output logic                               s_cyc_o,
   output logic                               s_stb_o,
   output logic                               s_we_o,
   output logic [ADR_WIDTH-1:0]               s_adr_o,
   output logic [DAT_WIDTH-1:0]               s_dat_o,
   output logic [DAT_WIDTH/8-1:0]             s_sel_o,
   input  logic                               s_ack_i,
   input  logic                               s_err_i,
   input  logic [DAT_WIDTH-1:0]               s_dat_i,
   output logic [NUM_MASTERS-1:0]             grant_o
);

   localparam int IDX_W = $clog2(NUM_MASTERS);
   localparam int SEL_W = DAT_WIDTH / 8;
   localparam int CNT_W = wait_cnt_width(TIMEOUT);

   logic [0:0]       r_state;
   logic [IDX_W-1:0] r_owner;
   logic [IDX_W-1:0] r_last;
   logic [CNT_W-1:0] r_wait;

   logic [IDX_W-1:0]       w_next_owner;
   logic                   w_req_valid;
   logic                   w_busy;
   logic                   w_own_cyc;
   logic                   w_own_stb;
   logic                   w_timeout;
   logic                   w_stb_out;
   logic [NUM_MASTERS-1:0] w_route;

   rr_arbiter #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_rr (
      .i_req   (m_cyc_i),
      .i_last  (r_last),
      .o_grant (w_next_owner),
      .o_valid (w_req_valid)
   );

   // Reset gates the bus immediately so nothing leaks out while rst is high.
   assign w_busy    = (r_state == ST_BUSY) && !rst;
   assign w_own_cyc = m_cyc_i[r_owner];
   assign w_own_stb = m_stb_i[r_owner];
   assign w_timeout = (TIMEOUT > 0) && w_busy && w_own_cyc && w_own_stb &&
                      (r_wait == CNT_W'(TIMEOUT));
   assign w_stb_out = w_busy && w_own_cyc && w_own_stb && !w_timeout;

   assign s_cyc_o = w_busy && w_own_cyc;
   assign s_stb_o = w_stb_out;
   assign s_we_o  = w_busy && m_we_i[r_owner];
   assign s_adr_o = w_busy ? m_adr_i[r_owner*ADR_WIDTH +: ADR_WIDTH] : '0;
   assign s_dat_o = w_busy ? m_dat_i[r_owner*DAT_WIDTH +: DAT_WIDTH] : '0;
   assign s_sel_o = w_busy ? m_sel_i[r_owner*SEL_W +: SEL_W] : '0;
   assign m_dat_o = s_dat_i;

   // Responses reach only an owner still holding cyc, so abandoned transfers drop late acks.
   generate
      for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_route
         assign grant_o[gi] = w_busy && (r_owner == IDX_W'(gi));
         assign w_route[gi] = grant_o[gi] && w_own_cyc;
         assign m_err_o[gi] = w_route[gi] && (s_err_i || w_timeout);
         assign m_ack_o[gi] = w_route[gi] && s_ack_i && !s_err_i && !w_timeout;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_owner <= '0;
         r_last  <= IDX_W'(NUM_MASTERS - 1);
         r_wait  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_wait <= '0;
               if (w_req_valid) begin
                  r_state <= ST_BUSY;
                  r_owner <= w_next_owner;
               end
            end
            default: begin
               if (!w_own_cyc) begin
                  r_state <= ST_IDLE;
                  r_last  <= r_owner;
                  r_wait  <= '0;
               end else if (w_timeout || !w_stb_out || s_ack_i || s_err_i) begin
                  r_wait <= '0;
               end else if (TIMEOUT > 0) begin
                  r_wait <= r_wait + CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (2 masters, TIMEOUT=4): expectations are
// queued as stimulus is applied and popped when the outputs settle.
module tb_wb_arbiter;

   localparam int NM = 2;
   localparam int AW = 30;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
   logic [NM*AW-1:0]  m_adr_i;
   logic [NM*DW-1:0]  m_dat_i;
   logic [NM*DW/8-1:0] m_sel_i;
   logic [NM-1:0]     m_ack_o, m_err_o;
   logic [DW-1:0]     m_dat_o;
   logic              s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0]     s_adr_o;
   logic [DW-1:0]     s_dat_o;
   logic [DW/8-1:0]   s_sel_o;
   logic              s_ack_i, s_err_i;
   logic [DW-1:0]     s_dat_i;
   logic [NM-1:0]     grant_o;

   wb_arbiter #(
      .NUM_MASTERS (NM),
      .ADR_WIDTH   (AW),
      .DAT_WIDTH   (DW),
      .TIMEOUT     (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .m_cyc_i (m_cyc_i),
      .m_stb_i (m_stb_i),
      .m_we_i  (m_we_i),
      .m_adr_i (m_adr_i),
      .m_dat_i (m_dat_i),
      .m_sel_i (m_sel_i),
      .m_ack_o (m_ack_o),
      .m_err_o (m_err_o),
      .m_dat_o (m_dat_o),
      .s_cyc_o (s_cyc_o),
      .s_stb_o (s_stb_o),
      .s_we_o  (s_we_o),
      .s_adr_o (s_adr_o),
      .s_dat_o (s_dat_o),
      .s_sel_o (s_sel_o),
      .s_ack_i (s_ack_i),
      .s_err_i (s_err_i),
      .s_dat_i (s_dat_i),
      .grant_o (grant_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic expect_push(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic check_pop(input logic [63:0] obs);
      exp_t e;
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_bad++;
         $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val)
         else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
         end
      end
      $display("check %-12s obs=%0h", (sb_q.size() == 0) ? "done" : "pending", obs);
   endtask

   // Packed control view: {grant, s_cyc, s_stb, m_ack, m_err}
   function automatic logic [63:0] ctl_vec();
      return 64'({grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input logic [1:0] g, input logic sc,
                       input logic ss, input logic [1:0] ak, input logic [1:0] er);
      expect_push(tag, 64'({g, sc, ss, ak, er}));
      #1;
      check_pop(ctl_vec());
   endtask

   initial begin
      logic [1:0] g;
      rst     = 1'b1;
      m_cyc_i = '0;
      m_stb_i = '0;
      m_we_i  = '0;
      m_adr_i = {30'h0000ABC, 30'h0001234};
      m_dat_i = {32'h11112222, 32'hCAFEF00D};
      m_sel_i = {4'h3, 4'hF};
      s_ack_i = 1'b0;
      s_err_i = 1'b0;
      s_dat_i = '0;

      // Reset state
      tick(); step("rst_a", 2'b00, 0, 0, 2'b00, 2'b00);
      tick(); step("rst_b", 2'b00, 0, 0, 2'b00, 2'b00);

      // Single master: one-cycle grant latency, ack routing, abandoned late ack
      tick(); rst = 1'b0; m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b01;
      step("t1_idle", 2'b00, 0, 0, 2'b00, 2'b00);
      tick(); step("t1_grant", 2'b01, 1, 1, 2'b00, 2'b00);
      expect_push("t1_adr", 64'(30'h0001234)); check_pop(64'(s_adr_o));
      expect_push("t1_wdat", 64'(32'hCAFEF00D)); check_pop(64'(s_dat_o));
      expect_push("t1_sel_we", 64'({4'hF, 1'b1})); check_pop(64'({s_sel_o, s_we_o}));
      s_ack_i = 1'b1; s_dat_i = 32'h5A5AA5A5;
      step("t1_ack", 2'b01, 1, 1, 2'b01, 2'b00);
      expect_push("t1_rdat", 64'(32'h5A5AA5A5)); check_pop(64'(m_dat_o));
      tick(); m_cyc_i = 2'b00; m_stb_i = 2'b00; m_we_i = 2'b00;
      step("t1_late_ack", 2'b01, 0, 0, 2'b00, 2'b00);
      tick(); s_ack_i = 1'b0;
      step("t1_idle2", 2'b00, 0, 0, 2'b00, 2'b00);

      // Fresh reset, both masters contend: grants alternate with an idle gap
      tick(); rst = 1'b1; step("rst2", 2'b00, 0, 0, 2'b00, 2'b00);
      for (int r = 0; r < 4; r++) begin
         g = 2'b01 << (r % 2);
         tick(); rst = 1'b0; m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1'b0;
         step("t2_idle", 2'b00, 0, 0, 2'b00, 2'b00);
         tick(); s_ack_i = 1'b1;
         step("t2_grant", g, 1, 1, g, 2'b00);
         tick(); s_ack_i = 1'b0; m_cyc_i = 2'b11 & ~g; m_stb_i = 2'b11 & ~g;
         step("t2_release", g, 0, 0, 2'b00, 2'b00);
      end

      // Master 1 bursts 4 strobes while master 0 waits: no preemption
      tick(); m_cyc_i = 2'b10; m_stb_i = 2'b10;
      step("t3_idle", 2'b00, 0, 0, 2'b00, 2'b00);
      tick(); step("t3_grant", 2'b10, 1, 1, 2'b00, 2'b00);
      for (int k = 0; k < 4; k++) begin
         tick(); m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1'b1;
         step("t3_burst", 2'b10, 1, 1, 2'b10, 2'b00);
         expect_push("t3_adr", 64'(30'h0000ABC)); check_pop(64'(s_adr_o));
      end
      tick(); m_cyc_i = 2'b01; m_stb_i = 2'b01; s_ack_i = 1'b0;
      step("t3_release", 2'b10, 0, 0, 2'b00, 2'b00);
      tick(); step("t3_gap", 2'b00, 0, 0, 2'b00, 2'b00);

      // Master 0 strobes into a silent slave: error on the 5th strobe cycle
      for (int k = 1; k <= 4; k++) begin
         tick(); step("t4_wait", 2'b01, 1, 1, 2'b00, 2'b00);
      end
      tick(); step("t4_timeout", 2'b01, 1, 0, 2'b00, 2'b01);
      tick(); step("t4_resume", 2'b01, 1, 1, 2'b00, 2'b00);

      // Simultaneous ack and err: err wins
      tick(); s_ack_i = 1'b1; s_err_i = 1'b1;
      step("t5_ack_err", 2'b01, 1, 1, 2'b00, 2'b01);
      tick(); s_ack_i = 1'b0; s_err_i = 1'b0; m_cyc_i = 2'b00; m_stb_i = 2'b00;
      step("t5_release", 2'b01, 0, 0, 2'b00, 2'b00);

      // Reset mid-transfer, then contention restarts from master 0
      tick(); m_cyc_i = 2'b01; m_stb_i = 2'b01;
      step("t6_idle", 2'b00, 0, 0, 2'b00, 2'b00);
      tick(); step("t6_grant", 2'b01, 1, 1, 2'b00, 2'b00);
      tick(); rst = 1'b1; s_ack_i = 1'b1;
      step("t6_in_rst", 2'b00, 0, 0, 2'b00, 2'b00);
      tick(); rst = 1'b0; s_ack_i = 1'b0; m_cyc_i = 2'b11; m_stb_i = 2'b11;
      step("t6_after_rst", 2'b00, 0, 0, 2'b00, 2'b00);
      tick(); s_ack_i = 1'b1;
      step("t6_first", 2'b01, 1, 1, 2'b01, 2'b00);
      tick(); s_ack_i = 1'b0; m_cyc_i = 2'b10; m_stb_i = 2'b10;
      step("t6_release", 2'b01, 0, 0, 2'b00, 2'b00);
      tick(); step("t6_gap", 2'b00, 0, 0, 2'b00, 2'b00);
      tick(); step("t6_second", 2'b10, 1, 1, 2'b00, 2'b00);

      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of Wishbone master ports (2..8).
REQ-002 SHALL have parameter ADR_WIDTH, default 30, word address width.
REQ-003 SHALL have parameter DAT_WIDTH, default 32, data width; SEL width = DAT_WIDTH/8.
REQ-004 SHALL have parameter TIMEOUT, default 255, max slave wait cycles; 0 disables timeout.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  system clock, all logic on rising edge.
REQ-006 SHALL have rst  in  1  synchronous active-high reset.
REQ-007 SHALL have m_cyc_i, m_stb_i, m_we_i  in  NUM_MASTERS  per-master cycle, strobe and write-enable.
REQ-008 SHALL have m_adr_i  in  NUM_MASTERS*ADR_WIDTH  packed master addresses, master 0 in LSBs.
REQ-009 SHALL have m_dat_i  in  NUM_MASTERS*DAT_WIDTH, and m_sel_i  in  NUM_MASTERS*DAT_WIDTH/8, packed write data and byte selects.
REQ-010 SHALL have m_ack_o, m_err_o  out  NUM_MASTERS  per-master acknowledge and error.
REQ-011 SHALL have m_dat_o  out  DAT_WIDTH  read data, broadcast to all masters.
REQ-012 SHALL have s_cyc_o, s_stb_o, s_we_o  out  1; s_adr_o  out  ADR_WIDTH; s_dat_o  out  DAT_WIDTH; s_sel_o  out  DAT_WIDTH/8  slave-side bus.
REQ-013 SHALL have s_ack_i, s_err_i  in  1; s_dat_i  in  DAT_WIDTH  slave response.
REQ-014 SHALL have grant_o  out  NUM_MASTERS  one-hot current owner, all zero when idle.

Function
REQ-015 SHALL implement states IDLE and BUSY with a registered owner index and a registered last-owner index.
REQ-016 In IDLE, when any m_cyc_i is high, SHALL grant round-robin, searching from last-owner+1 upward with wrap-around, and enter BUSY on the next edge.
REQ-017 Request-to-grant latency SHALL be exactly one cycle: s_cyc_o first high the cycle after m_cyc_i rises on an idle bus.
REQ-018 In BUSY, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o SHALL combinationally follow the owner's inputs.
REQ-019 In BUSY, s_ack_i and s_err_i SHALL route only to the owner's m_ack_o/m_err_o; all other masters see 0.
REQ-020 m_dat_o SHALL equal s_dat_i at all times.
REQ-021 Ownership SHALL persist across multiple strobes while the owner keeps m_cyc_i high (no preemption).
REQ-022 When owner's m_cyc_i falls, SHALL return to IDLE next edge, record last-owner, leave one idle cycle before any new grant.
REQ-023 If s_ack_i and s_err_i are both high, SHALL forward err only and suppress ack.
REQ-024 Wait counter SHALL increment each BUSY cycle with s_stb_o high and no ack/err; clear on ack, err, stb low or IDLE.
REQ-025 When TIMEOUT>0 and the counter equals TIMEOUT, SHALL assert owner's m_err_o for one cycle, force s_stb_o low that cycle, clear the counter, and keep ownership.
REQ-026 In IDLE, all s_* outputs, m_ack_o, m_err_o and grant_o SHALL be 0.
REQ-027 A master dropping m_cyc_i with a strobe outstanding SHALL abandon the transfer; a late slave ack SHALL not reach any master.

Reset
REQ-028 rst SHALL force IDLE, counter 0, last-owner NUM_MASTERS-1 (master 0 highest priority first), effective next edge.
REQ-029 rst mid-transfer SHALL drop s_cyc_o and s_stb_o on the next cycle; pending ack/err SHALL be discarded.
REQ-030 All outputs SHALL be 0 during and immediately after reset.

Structure
REQ-031 State encoding, default widths and TIMEOUT default SHALL live in shared package wb_pkg.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_arbiter (request vector, last index -> grant index, valid).

Verification
REQ-033 Reset, then m_cyc_i=2'b01 at cycle 0 -> s_cyc_o=1 and grant_o=01 at cycle 1; slave ack -> m_ack_o[0]=1, m_ack_o[1]=0.
REQ-034 Both masters request continuously, each releasing after one ack -> grants alternate 0,1,0,1 with one idle cycle between.
REQ-035 Master 1 owns bus, master 0 requests mid-burst of 4 strobes -> master 1 keeps grant until its m_cyc_i falls.
REQ-036 TIMEOUT=4, slave never acks -> m_err_o[owner]=1 exactly at 5th strobe cycle, s_stb_o=0 that cycle.
REQ-037 s_ack_i=s_err_i=1 same cycle -> m_err_o[owner]=1, m_ack_o all 0.
REQ-038 rst asserted while master 0 strobes -> s_cyc_o=0 next cycle; after release both requesting -> master 0 granted first.
